// File: rtl/traffic_phase_sched.sv
`default_nettype none
// traffic_phase_sched: tick-driven two-pole phase sequencer with actuated greens,
// pedestrian walk insertion and emergency pre-emption. Rev 1.0
module traffic_phase_sched #(
  parameter int T_GMIN = 5,
  parameter int T_YEL  = 3,
  parameter int T_AR   = 1,
  parameter int T_PED  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sens1,
  input  logic       sens2,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] pole1,
  output logic [2:0] pole2,
  output logic       walk,
  output logic [3:0] count
);

  typedef enum logic [2:0] {
    G1  = 3'd0,
    Y1  = 3'd1,
    AR1 = 3'd2,
    PED = 3'd3,
    G2  = 3'd4,
    Y2  = 3'd5,
    AR2 = 3'd6,
    EMG = 3'd7
  } state_t;

  localparam logic [3:0] C_GMIN = 4'(T_GMIN);
  localparam logic [3:0] C_YEL  = 4'(T_YEL);
  localparam logic [3:0] C_AR   = 4'(T_AR);
  localparam logic [3:0] C_PED  = 4'(T_PED);

  state_t     state;
  state_t     nxt_state;
  logic [3:0] nxt_count;
  logic       ped_pend;
  logic       ped_from_ar1;
  logic       ped_served;
  logic       emg_pend;
  logic       nxt_from_ar1;
  logic       nxt_served;
  logic       nxt_emg_pend;
  logic       timer_done;
  logic       enter_ped;

  function automatic logic [2:0] lamp1(input state_t s);
    case (s)
      G1:      lamp1 = 3'b001;
      Y1:      lamp1 = 3'b010;
      default: lamp1 = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lamp2(input state_t s);
    case (s)
      G2:      lamp2 = 3'b001;
      Y2:      lamp2 = 3'b010;
      default: lamp2 = 3'b100;
    endcase
  endfunction

  always_comb begin
    nxt_state    = state;
    nxt_count    = count;
    nxt_from_ar1 = ped_from_ar1;
    nxt_served   = ped_served;
    nxt_emg_pend = emg_pend;
    timer_done   = tick && (count <= 4'd1);
    case (state)
      G1, G2: begin
        if (emerg) begin
          nxt_state    = (state == G1) ? Y1 : Y2;
          nxt_count    = C_YEL;
          nxt_emg_pend = 1'b1;
        end else if (tick) begin
          if (!timer_done) begin
            nxt_count = count - 4'd1;
          end else if ((state == G1) ? (sens2 | ped_pend) : (sens1 | ped_pend)) begin
            nxt_state = (state == G1) ? Y1 : Y2;
            nxt_count = C_YEL;
          end else begin
            nxt_count = 4'd0;
          end
        end
      end
      Y1, Y2: begin
        // an emergency seen at any point of yellow diverts its end to EMG
        if (emerg) nxt_emg_pend = 1'b1;
        if (tick) begin
          if (!timer_done) begin
            nxt_count = count - 4'd1;
          end else begin
            nxt_emg_pend = 1'b0;
            if (emg_pend || emerg) begin
              nxt_state = EMG;
              nxt_count = 4'd0;
            end else begin
              nxt_state = (state == Y1) ? AR1 : AR2;
              nxt_count = C_AR;
            end
          end
        end
      end
      AR1, AR2: begin
        if (emerg) begin
          nxt_state = EMG;
          nxt_count = 4'd0;
        end else if (tick) begin
          if (!timer_done) begin
            nxt_count = count - 4'd1;
          end else if (ped_pend && !ped_served) begin
            nxt_state    = PED;
            nxt_count    = C_PED;
            nxt_from_ar1 = (state == AR1);
          end else begin
            nxt_state  = (state == AR1) ? G2 : G1;
            nxt_count  = C_GMIN;
            nxt_served = 1'b0;
          end
        end
      end
      PED: begin
        if (emerg) begin
          nxt_state = EMG;
          nxt_count = 4'd0;
        end else if (tick) begin
          if (!timer_done) begin
            nxt_count = count - 4'd1;
          end else begin
            // return through the clearance state we came from; it then hands over
            nxt_state  = ped_from_ar1 ? AR1 : AR2;
            nxt_count  = C_AR;
            nxt_served = 1'b1;
          end
        end
      end
      EMG: begin
        nxt_count = 4'd0;
        if (!emerg) begin
          nxt_state  = AR2;
          nxt_count  = C_AR;
          nxt_served = 1'b0;
        end
      end
      default: begin
        nxt_state = G1;
        nxt_count = C_GMIN;
      end
    endcase
    enter_ped = (nxt_state == PED) && (state != PED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= G1;
      count        <= C_GMIN;
      ped_pend     <= 1'b0;
      ped_from_ar1 <= 1'b0;
      ped_served   <= 1'b0;
      emg_pend     <= 1'b0;
      pole1        <= 3'b001;
      pole2        <= 3'b100;
      walk         <= 1'b0;
    end else begin
      state        <= nxt_state;
      count        <= nxt_count;
      ped_pend     <= ped_req | (ped_pend & ~enter_ped);
      ped_from_ar1 <= nxt_from_ar1;
      ped_served   <= nxt_served;
      emg_pend     <= nxt_emg_pend;
      pole1        <= lamp1(nxt_state);
      pole2        <= lamp2(nxt_state);
      walk         <= (nxt_state == PED);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sched.sv
`default_nettype none
// tb_traffic_phase_sched: directed scenarios plus randomized traffic, every clk
// compared against a phase-level reference model of the intersection.
module tb_traffic_phase_sched;

  localparam int T_GMIN = 5;
  localparam int T_YEL  = 3;
  localparam int T_AR   = 1;
  localparam int T_PED  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       sens1 = 1'b0;
  logic       sens2 = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic [2:0] pole1;
  logic [2:0] pole2;
  logic       walk;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_sched #(
    .T_GMIN(T_GMIN), .T_YEL(T_YEL), .T_AR(T_AR), .T_PED(T_PED)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .sens1(sens1), .sens2(sens2),
    .ped_req(ped_req), .emerg(emerg), .pole1(pole1), .pole2(pole2),
    .walk(walk), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: phase name, seconds left, and the intersection's memory
  string m_ph;
  int    m_rem;
  bit    m_pend;
  bit    m_walked;
  bit    m_home1;
  bit    m_flush;

  function automatic int lamp_of(input string ph, input int pole);
    if ((pole == 1 && ph == "G1") || (pole == 2 && ph == "G2")) return 1;
    if ((pole == 1 && ph == "Y1") || (pole == 2 && ph == "Y2")) return 2;
    return 4;
  endfunction

  function automatic int max_of(input string ph);
    if (ph == "G1" || ph == "G2") return T_GMIN;
    if (ph == "Y1" || ph == "Y2") return T_YEL;
    if (ph == "AR1" || ph == "AR2") return T_AR;
    if (ph == "PED") return T_PED;
    return 0;
  endfunction

  task automatic model_reset();
    m_ph = "G1"; m_rem = T_GMIN; m_pend = 0; m_walked = 0; m_home1 = 0; m_flush = 0;
  endtask

  task automatic model_step(input bit tk, input bit s1, input bit s2, input bit pr, input bit em);
    string nph;
    int    nrem;
    bit    one;
    bit    dem;
    nph  = m_ph;
    nrem = m_rem;
    if (m_ph == "G1" || m_ph == "G2") begin
      one = (m_ph == "G1");
      dem = (one ? s2 : s1) | m_pend;
      if (em) begin
        nph = one ? "Y1" : "Y2"; nrem = T_YEL; m_flush = 1;
      end else if (tk) begin
        if (m_rem > 1) nrem = m_rem - 1;
        else if (dem) begin nph = one ? "Y1" : "Y2"; nrem = T_YEL; end
        else nrem = 0;
      end
    end else if (m_ph == "Y1" || m_ph == "Y2") begin
      if (em) m_flush = 1;
      if (tk) begin
        if (m_rem > 1) nrem = m_rem - 1;
        else begin
          if (m_flush) begin nph = "EMG"; nrem = 0; end
          else begin nph = (m_ph == "Y1") ? "AR1" : "AR2"; nrem = T_AR; end
          m_flush = 0;
        end
      end
    end else if (m_ph == "AR1" || m_ph == "AR2") begin
      if (em) begin
        nph = "EMG"; nrem = 0;
      end else if (tk) begin
        if (m_rem > 1) nrem = m_rem - 1;
        else if (m_pend && !m_walked) begin
          nph = "PED"; nrem = T_PED; m_home1 = (m_ph == "AR1");
        end else begin
          nph = (m_ph == "AR1") ? "G2" : "G1"; nrem = T_GMIN; m_walked = 0;
        end
      end
    end else if (m_ph == "PED") begin
      if (em) begin
        nph = "EMG"; nrem = 0;
      end else if (tk) begin
        if (m_rem > 1) nrem = m_rem - 1;
        else begin nph = m_home1 ? "AR1" : "AR2"; nrem = T_AR; m_walked = 1; end
      end
    end else begin
      nrem = 0;
      if (!em) begin nph = "AR2"; nrem = T_AR; m_walked = 0; end
    end
    if (nph == "PED" && m_ph != "PED") m_pend = pr;
    else m_pend = m_pend | pr;
    m_ph  = nph;
    m_rem = nrem;
  endtask

  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step(tick, sens1, sens2, ped_req, emerg);
    #1;
    check_eq("m_pole1", int'(pole1), lamp_of(m_ph, 1));
    check_eq("m_pole2", int'(pole2), lamp_of(m_ph, 2));
    check_eq("m_walk", int'(walk), (m_ph == "PED") ? 1 : 0);
    check_eq("m_count", int'(count), m_rem);
    check_eq("both_green", int'(pole1 != 3'b100 && pole2 != 3'b100), 0);
    check_eq("onehot1", int'($onehot(pole1)), 1);
    check_eq("onehot2", int'($onehot(pole2)), 1);
    check_eq("cnt_bound", int'(int'(count) <= max_of(m_ph)), 1);
  end

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  int first;
  int found_cnt;
  int emg_left;

  initial begin
    // reset and resting in G1 without demand
    apply_reset();
    check_eq("rst_pole1", int'(pole1), 1);
    check_eq("rst_pole2", int'(pole2), 4);
    check_eq("rst_walk", int'(walk), 0);
    check_eq("rst_count", int'(count), T_GMIN);
    for (int k = 1; k <= 10; k++) begin
      pulse_tick();
      check_eq("rest_count", int'(count), (T_GMIN - k > 0) ? T_GMIN - k : 0);
      check_eq("rest_pole1", int'(pole1), 1);
      check_eq("rest_pole2", int'(pole2), 4);
    end

    // vehicle demand on pole2: green arrives after GMIN+YEL+AR ticks
    apply_reset();
    sens2 = 1'b1;
    first = -1;
    found_cnt = -1;
    for (int k = 1; k <= 14 && first < 0; k++) begin
      pulse_tick();
      if (pole2 == 3'b001) begin first = k; found_cnt = int'(count); end
    end
    check_eq("g2_arrival", first, T_GMIN + T_YEL + T_AR);
    check_eq("g2_count", found_cnt, T_GMIN);
    sens2 = 1'b0;

    // emergency in the middle of G2
    pulse_tick();
    pulse_tick();
    check_eq("g2_mid_count", int'(count), 3);
    @(negedge clk) emerg = 1'b1;
    @(negedge clk);
    check_eq("emg_y2_pole2", int'(pole2), 2);
    check_eq("emg_y2_count", int'(count), T_YEL);
    repeat (T_YEL) pulse_tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("emg_pole1", int'(pole1), 4);
      check_eq("emg_pole2", int'(pole2), 4);
      check_eq("emg_count", int'(count), 0);
      pulse_tick();
    end
    @(negedge clk) emerg = 1'b0;
    @(negedge clk);
    check_eq("emg_ar2_count", int'(count), T_AR);
    check_eq("emg_ar2_pole1", int'(pole1), 4);
    pulse_tick();
    check_eq("emg_g1_pole1", int'(pole1), 1);
    check_eq("emg_g1_count", int'(count), T_GMIN);

    // pedestrian request during G1 with no vehicles
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    repeat (T_GMIN + T_YEL + T_AR) pulse_tick();
    check_eq("ped_walk", int'(walk), 1);
    check_eq("ped_count", int'(count), T_PED);
    for (int k = 1; k < T_PED; k++) begin
      pulse_tick();
      check_eq("ped_walk_run", int'(walk), 1);
      check_eq("ped_count_run", int'(count), T_PED - k);
    end
    pulse_tick();
    check_eq("ped_exit_walk", int'(walk), 0);
    check_eq("ped_exit_count", int'(count), T_AR);
    pulse_tick();
    check_eq("ped_next_g2", int'(pole2), 1);

    // reset in the middle of a walk
    @(negedge clk) ped_req = 1'b1;
    @(negedge clk) ped_req = 1'b0;
    repeat (T_GMIN + T_YEL + T_AR) pulse_tick();
    check_eq("ped2_walk", int'(walk), 1);
    pulse_tick();
    pulse_tick();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_pole1", int'(pole1), 1);
    check_eq("mid_rst_pole2", int'(pole2), 4);
    check_eq("mid_rst_walk", int'(walk), 0);
    check_eq("mid_rst_count", int'(count), T_GMIN);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (T_GMIN + 1) pulse_tick();
    check_eq("no_pend_pole1", int'(pole1), 1);
    check_eq("no_pend_count", int'(count), 0);

    // randomized traffic, pedestrians and emergencies
    emg_left = 0;
    for (int t = 0; t < 2000; t++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        tick = (c == 0);
        if ($urandom_range(0, 15) == 0) sens1 = ~sens1;
        if ($urandom_range(0, 15) == 0) sens2 = ~sens2;
        ped_req = ($urandom_range(0, 39) == 0);
        if (emg_left > 0) emg_left--;
        else if (emerg) emerg = 1'b0;
        else if ($urandom_range(0, 199) == 0) begin
          emerg = 1'b1;
          emg_left = $urandom_range(3, 60);
        end
      end
    end
    @(negedge clk);
    tick = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
